// File: rtl/audio_bar_frame_ctrl.sv
// audio_bar_frame_ctrl
// Double-buffered bar-magnitude store with frame-synchronous swap, plus a
// registered per-pixel bar renderer driven by the raster position.
module audio_bar_frame_ctrl #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int COORD_WIDTH   = 16,
    parameter int NUM_BARS      = 32,
    parameter int BAR_GAP       = 2,
    parameter int MAG_WIDTH     = 9,
    parameter int IDX_WIDTH     = 5
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          frame_pulse,
    input  logic signed [COORD_WIDTH-1:0] row,
    input  logic signed [COORD_WIDTH-1:0] col,
    input  logic                          s_valid,
    input  logic [MAG_WIDTH-1:0]          s_data,
    input  logic                          s_last,
    output logic                          s_ready,
    output logic                          pixel_on,
    output logic [IDX_WIDTH-1:0]          bar_idx,
    output logic                          frame_swapped,
    output logic                          len_err
);

    localparam int BAR_PIX   = SCREEN_WIDTH / NUM_BARS;
    localparam int SUB_WIDTH = (BAR_PIX > 1) ? $clog2(BAR_PIX) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_PEND = 2'd2;

    localparam logic signed [COORD_WIDTH-1:0] W_S = COORD_WIDTH'(SCREEN_WIDTH);
    localparam logic signed [COORD_WIDTH-1:0] H_S = COORD_WIDTH'(SCREEN_HEIGHT);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_BARS - 1);
    localparam logic [SUB_WIDTH-1:0] SUB_LAST = SUB_WIDTH'(BAR_PIX - 1);
    localparam logic [SUB_WIDTH-1:0] SUB_LIT  = SUB_WIDTH'(BAR_PIX - BAR_GAP);

    logic [1:0]           state;
    logic [IDX_WIDTH-1:0] wr_idx;
    logic                 front_sel;
    logic [MAG_WIDTH-1:0] bank [2][NUM_BARS];

    logic accept, at_last, term, swap;

    assign s_ready = (state != ST_PEND);
    assign accept  = s_valid && s_ready;
    assign at_last = (wr_idx == LAST_IDX);
    assign term    = accept && (s_last || at_last);
    assign swap    = (state == ST_PEND) && frame_pulse;

    // Batch capture into the back bank and frame-aligned bank swap
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= ST_IDLE;
            wr_idx        <= '0;
            front_sel     <= 1'b0;
            frame_swapped <= 1'b0;
            len_err       <= 1'b0;
            for (int b = 0; b < NUM_BARS; b++) begin
                bank[0][b] <= '0;
                bank[1][b] <= '0;
            end
        end else begin
            frame_swapped <= 1'b0;
            if (accept) begin
                bank[~front_sel][wr_idx] <= s_data;
                wr_idx <= wr_idx + 1'b1;
                state  <= term ? ST_PEND : ST_FILL;
                // Batch length must be exactly NUM_BARS: early s_last or a
                // missing s_last on the final slot are both errors.
                if (s_last != at_last)
                    len_err <= 1'b1;
            end else if (swap) begin
                front_sel     <= ~front_sel;
                frame_swapped <= 1'b1;
                wr_idx        <= '0;
                state         <= ST_IDLE;
            end
        end
    end

    // Bar position of the current column: counters restart at col 0 and
    // follow the one-column-per-clock raster, so no divider is needed.
    logic [SUB_WIDTH-1:0] sub_q, cur_sub;
    logic [IDX_WIDTH-1:0] bar_q, cur_bar;
    logic                 col_zero;

    assign col_zero = (col == '0);
    assign cur_sub  = col_zero ? '0 : sub_q;
    assign cur_bar  = col_zero ? '0 : bar_q;

    // Advance the (bar, sub) pair; bar saturates so the bank index stays legal
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sub_q <= '0;
            bar_q <= '0;
        end else if (cur_sub == SUB_LAST) begin
            sub_q <= '0;
            bar_q <= (cur_bar == LAST_IDX) ? cur_bar : cur_bar + 1'b1;
        end else begin
            sub_q <= cur_sub + 1'b1;
            bar_q <= cur_bar;
        end
    end

    // Height test; the swapping bank is used already on the pulse pixel
    logic                          eff_sel;
    logic [MAG_WIDTH-1:0]          mag;
    logic signed [COORD_WIDTH-1:0] mag_ext, mag_clamp, thresh;
    logic                          in_col, in_row, lit;

    assign eff_sel   = front_sel ^ swap;
    assign mag       = bank[eff_sel][cur_bar];
    assign mag_ext   = $signed({{(COORD_WIDTH-MAG_WIDTH){1'b0}}, mag});
    assign mag_clamp = (mag_ext > H_S) ? H_S : mag_ext;
    assign thresh    = H_S - mag_clamp;
    assign in_col    = !col[COORD_WIDTH-1] && (col < W_S);
    assign in_row    = !row[COORD_WIDTH-1] && (row < H_S);
    assign lit       = in_col && in_row && (cur_sub < SUB_LIT) && (row >= thresh);

    // One-clock registered pixel output, aligned with the bar index
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pixel_on <= 1'b0;
            bar_idx  <= '0;
        end else begin
            pixel_on <= lit;
            bar_idx  <= cur_bar;
        end
    end

endmodule

// File: doc/audio_bar_frame_ctrl.md
# audio_bar_frame_ctrl

Frame-synchronous display controller between the audio spectrum path and the VGA timing generator. Accepts one batch of bar magnitudes per audio update into a back buffer over a valid/ready stream. Swaps that buffer to the front only on the timing generator's frame pulse, so no frame shows a partial update. From the incoming `row`/`col` raster position it produces a registered per-pixel `pixel_on` for the colour stage.

## Interface

Parameters:
- `SCREEN_WIDTH`, 640: active columns.
- `SCREEN_HEIGHT`, 480: active rows.
- `COORD_WIDTH`, 16: width of signed `row`/`col`.
- `NUM_BARS`, 32: bars per frame. `SCREEN_WIDTH` must be divisible by `NUM_BARS`. `BAR_PIX = SCREEN_WIDTH/NUM_BARS` (20).
- `BAR_GAP`, 2: unlit columns at the right edge of each bar. Must satisfy `BAR_GAP < BAR_PIX`.
- `MAG_WIDTH`, 9: bar magnitude width.
- `IDX_WIDTH`, 5: `clog2(NUM_BARS)`.

Ports:
- `clk`  in  1  pixel clock, shared with the sync generator.
- `resetn`  in  1  asynchronous, active-low reset.
- `frame_pulse`  in  1  single-cycle pulse at `row==0 && col==0`.
- `row`, `col`  in  `COORD_WIDTH` signed  current raster position. `col` advances by 1 per clock.
- `s_valid`  in  1  magnitude beat valid.
- `s_data`  in  `MAG_WIDTH`  bar magnitude in pixels, unsigned.
- `s_last`  in  1  final beat of the batch.
- `s_ready`  out  1  controller can accept a beat.
- `pixel_on`  out  1  registered, 1-cycle latency: bar pixel lit.
- `bar_idx`  out  `IDX_WIDTH`  registered bar index of the pixel reported on `pixel_on`.
- `frame_swapped`  out  1  one-cycle pulse: a swap took effect.
- `len_err`  out  1  sticky: a batch length was not equal to `NUM_BARS`.

## Operation

- Storage is two banks of `NUM_BARS` x `MAG_WIDTH` registers. `front_sel` selects the displayed bank; the other bank is the back bank.
- State machine:
  - `IDLE`: `s_ready=1`. An accepted beat writes `back[0]`, sets `wr_idx=1`, and moves to `FILL`. If that beat is also a terminating beat, it moves to `PENDING` instead.
  - `FILL`: `s_ready=1`. Each accepted beat writes `back[wr_idx]` and increments `wr_idx`.
  - `PENDING`: `s_ready=0`. Waits for `frame_pulse`. On `frame_pulse`, toggles `front_sel`, pulses `frame_swapped`, clears `wr_idx`, and returns to `IDLE`.
- A beat is accepted when `s_valid && s_ready`.
- A terminating beat is an accepted beat with `s_last=1`, or the `NUM_BARS`-th accepted beat. A terminating beat moves the FSM to `PENDING`.
- Batch length errors:
  - Batch terminated by `s_last` before `NUM_BARS` beats: set `len_err`. Unwritten back entries keep their old values.
  - `NUM_BARS`-th beat accepted with `s_last=0`: set `len_err`. The batch closes; the next beat starts a new batch after the swap.
- `frame_pulse` in `IDLE` or `FILL` has no effect. A partial batch is never swapped.
- Terminating beat in the same cycle as `frame_pulse`: the FSM enters `PENDING`. The swap occurs on the next `frame_pulse`, not this one.
- Bar index:
  - Tracked with a counter pair (`bar`, `sub`), reset whenever `col==0`. `sub` wraps at `BAR_PIX-1` and then increments `bar`. No divider is used.
  - Result must equal `floor(col/BAR_PIX)` for every active column.
- `pixel_on` is registered and equals the AND of:
  - `0 <= col < SCREEN_WIDTH`;
  - `0 <= row < SCREEN_HEIGHT`;
  - `sub < BAR_PIX-BAR_GAP`;
  - `row >= SCREEN_HEIGHT - min(front[bar], SCREEN_HEIGHT)`.
- Magnitudes of `SCREEN_HEIGHT` or more clamp to a full-height bar. A magnitude of 0 lights nothing.
- Effective front bank for the lookup is `front_sel ^ (state==PENDING && frame_pulse)`. Pixel (0,0) of a frame therefore already uses the newly swapped bank.
- Arithmetic: the height comparison uses signed `COORD_WIDTH` with a zero-extended magnitude. Negative `row`/`col` give `pixel_on=0`.

## Timing

- Reset (asynchronous, immediate) sets:
  - both banks all-zero, `front_sel=0`;
  - state `IDLE`, `wr_idx=0`;
  - `s_ready=1` (combinational from state, so 1 during reset);
  - `pixel_on=0`, `bar_idx=0`, `frame_swapped=0`, `len_err=0`.
- Reset mid-batch or in `PENDING` discards the batch. No swap occurs.
- `pixel_on` and `bar_idx` lag `row`/`col` by exactly 1 clock. Downstream delays hsync, vsync and data_enable by 1 clock to align.
- `frame_swapped` is high in the cycle after the `frame_pulse` edge that performs the swap.
- Batch-to-display latency: from the terminating beat to the next `frame_pulse`, up to one full frame (800x525 clocks).
- `s_ready` falls in the cycle after the terminating beat. It rises in the cycle after the swap.

## Test plan

- Reset, then full batch of 32 beats with values 0..31x15, `s_last` on beat 32, then run 2 frames → `frame_swapped` pulses once at frame start. Column 20..37 lights rows 465..479 (bar 1 = 15). Columns 38..39 stay dark.
- Batch completes mid-frame → the current frame still shows the old bank at every pixel. The new bank appears from pixel (0,0) of the next frame.
- Terminating beat coincident with `frame_pulse` → no swap that frame. Swap and `frame_swapped` occur one frame later. `s_ready=0` throughout.
- Short batch (`s_last` on beat 10) → `len_err=1`. Bars 10..31 keep their prior values after the swap. 33 beats without `s_last` → batch closes at 32, `len_err=1`, beat 33 held off by `s_ready=0`.
- Magnitude 511 and 0 → bar fully lit on rows 0..479; bar with 0 is dark. `bar_idx` matches `floor(col/20)` for all 640 columns.
- Assert `resetn=0` during `FILL` and in `PENDING` → outputs reach their reset values immediately. The display is all dark, with no swap on the following `frame_pulse`.
